alu_dec_pipe: RTL and testbench



---
 rtl/alu_dec_pipe_pkg.sv | 68 ++++++
 rtl/alu_dec_pipe_core.sv | 54 +++++
 rtl/alu_dec_pipe.sv | 120 ++++++++++++
 tb/tb_alu_dec_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_dec_pipe_pkg.sv
// Shared encodings for the registered ALU decoder: ALU ops, opcodes, funct7 classes, M-unit codes.
// Also holds the FSM state type and the packed decode result carried to the output register.
package alu_dec_pipe_pkg;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLT    = 4'd5;
    localparam logic [3:0] ALU_SLTU   = 4'd6;
    localparam logic [3:0] ALU_SLL    = 4'd7;
    localparam logic [3:0] ALU_SRA    = 4'd8;
    localparam logic [3:0] ALU_SRL    = 4'd9;
    localparam logic [3:0] ALU_COPY_B = 4'd10;
    localparam logic [3:0] ALU_XXX    = 4'd15;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [6:0] FNC7_BASE   = 7'b0000000;
    localparam logic [6:0] FNC7_ALT    = 7'b0100000;
    localparam logic [6:0] FNC7_MULDIV = 7'b0000001;

    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic [2:0] md_op;
        logic       is_md;
        logic       illegal;
    } dec_t;

    // funct3 -> ALU op for the base (funct7 = 0) integer ops.
    function automatic logic [3:0] base_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  base_alu = ALU_ADD;
            3'b001:  base_alu = ALU_SLL;
            3'b010:  base_alu = ALU_SLT;
            3'b011:  base_alu = ALU_SLTU;
            3'b100:  base_alu = ALU_XOR;
            3'b101:  base_alu = ALU_SRL;
            3'b110:  base_alu = ALU_OR;
            default: base_alu = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_dec_pipe_core.sv
// Pure combinational RV32I/RV32M ALU decode; zero latency, no state, no flow control.
// md_op carries funct3 only for M ops and is 0 otherwise.
module alu_dec_core
    import alu_dec_pipe_pkg::*;
#(
    parameter int EN_M = 1
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output dec_t       dec
);

    always_comb begin
        dec.alu_op  = ALU_XXX;
        dec.md_op   = 3'd0;
        dec.is_md   = 1'b0;
        dec.illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == FNC7_BASE) begin
                    dec.alu_op = base_alu(funct3);
                end else if (funct7 == FNC7_ALT && funct3 == 3'b000) begin
                    dec.alu_op = ALU_SUB;
                end else if (funct7 == FNC7_ALT && funct3 == 3'b101) begin
                    dec.alu_op = ALU_SRA;
                end else if (funct7 == FNC7_MULDIV && EN_M != 0) begin
                    dec.is_md = 1'b1;
                    dec.md_op = funct3;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                // Shift-immediates carry the shift type in funct7; the rest is immediate.
                if (funct3 == 3'b001) begin
                    if (funct7 == FNC7_BASE) dec.alu_op = ALU_SLL;
                    else                     dec.illegal = 1'b1;
                end else if (funct3 == 3'b101) begin
                    if (funct7 == FNC7_BASE)     dec.alu_op = ALU_SRL;
                    else if (funct7 == FNC7_ALT) dec.alu_op = ALU_SRA;
                    else                         dec.illegal = 1'b1;
                end else begin
                    dec.alu_op = base_alu(funct3);
                end
            end
            OPC_LUI: dec.alu_op = ALU_COPY_B;
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE:
                dec.alu_op = ALU_ADD;
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_dec_pipe.sv
// Registered ALU decoder with valid/ready output and fixed-latency M-unit wait sequencing.
// Non-M ops: 1 cycle; M ops: 1+LAT cycles. Output held stable while !out_ready; in_ready=out_ready in HOLD.
module alu_dec_pipe
    import alu_dec_pipe_pkg::*;
#(
    parameter int ALUOP_W = 4,
    parameter int EN_M    = 1,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [6:0]         opcode,
    input  logic [2:0]         funct3,
    input  logic [6:0]         funct7,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [2:0]         md_op,
    output logic               is_md,
    output logic               illegal,
    output logic               md_start,
    output logic               busy
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_md_start;
    logic [ALUOP_W-1:0] r_alu_op;
    logic [2:0]         r_md_op;
    logic               r_is_md;
    logic               r_illegal;

    dec_t               w_dec;
    logic               w_in_ready;
    logic               w_accept;

    alu_dec_core #(.EN_M(EN_M)) u_core (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .dec    (w_dec)
    );

    assign w_in_ready = !flush && ((r_state == ST_IDLE) || (r_state == ST_HOLD && out_ready));
    assign w_accept   = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_md_start  <= 1'b0;
            r_alu_op    <= ALUOP_W'(ALU_XXX);
            r_md_op     <= 3'd0;
            r_is_md     <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_md_start <= 1'b0;
            if (flush) begin
                r_state     <= ST_IDLE;
                r_out_valid <= 1'b0;
                r_busy      <= 1'b0;
                r_cnt       <= '0;
            end else if (w_accept) begin
                r_alu_op  <= ALUOP_W'(w_dec.alu_op);
                r_md_op   <= w_dec.md_op;
                r_is_md   <= w_dec.is_md;
                r_illegal <= w_dec.illegal;
                if (w_dec.is_md) begin
                    r_state     <= ST_WAIT;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b1;
                    r_md_start  <= 1'b1;
                    r_cnt       <= (w_dec.md_op >= MD_DIV) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                end else begin
                    r_state     <= ST_HOLD;
                    r_out_valid <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_WAIT: begin
                        if (r_cnt == CNT_W'(1)) begin
                            r_state     <= ST_HOLD;
                            r_out_valid <= 1'b1;
                            r_busy      <= 1'b0;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                    ST_HOLD: begin
                        if (out_ready) begin
                            r_state     <= ST_IDLE;
                            r_out_valid <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign alu_op    = r_alu_op;
    assign md_op     = r_md_op;
    assign is_md     = r_is_md;
    assign illegal   = r_illegal;
    assign md_start  = r_md_start;
    assign busy      = r_busy;

endmodule

// File: tb/tb_alu_dec_pipe.sv
// Self-checking bench for alu_dec_pipe: decode vector table through a scoreboard plus
// hand-written latency, backpressure, flush and reset sequences.
module tb_alu_dec_pipe;
    import alu_dec_pipe_pkg::*;

    typedef struct packed {
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] alu;
        logic [2:0] md;
        logic       is_md;
        logic       ill;
    } vec_t;

    typedef struct packed {
        logic [3:0] alu;
        logic [2:0] md;
        logic       is_md;
        logic       ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       out_ready = 1'b1;
    logic       in_ready, out_valid, is_md, illegal, md_start, busy;
    logic [3:0] alu_op;
    logic [2:0] md_op;
    logic       nm_in_ready, nm_out_valid, nm_is_md, nm_illegal, nm_md_start, nm_busy;
    logic [3:0] nm_alu_op;
    logic [2:0] nm_md_op;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   rnd     = 1'b0;
    exp_t cur_exp = '0;
    exp_t sb_e;
    exp_t sb_q[$];
    vec_t tv[$];

    always #5 clk = ~clk;

    alu_dec_pipe #(.ALUOP_W(4), .EN_M(1), .MUL_LAT(2), .DIV_LAT(32), .CNT_W(6)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .out_valid(out_valid),
        .out_ready(out_ready), .alu_op(alu_op), .md_op(md_op), .is_md(is_md),
        .illegal(illegal), .md_start(md_start), .busy(busy)
    );

    alu_dec_pipe #(.ALUOP_W(4), .EN_M(0), .MUL_LAT(2), .DIV_LAT(32), .CNT_W(6)) u_dut_nom (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(nm_in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .out_valid(nm_out_valid),
        .out_ready(out_ready), .alu_op(nm_alu_op), .md_op(nm_md_op), .is_md(nm_is_md),
        .illegal(nm_illegal), .md_start(nm_md_start), .busy(nm_busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) step();
    endtask

    task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [3:0] a, input logic [2:0] m, input logic im, input logic il);
        opcode   = o;
        funct3   = f3;
        funct7   = f7;
        cur_exp  = '{alu: a, md: m, is_md: im, ill: il};
        in_valid = 1'b1;
    endtask

    // Scoreboard: push on accept, pop on output handshake; flush/reset kill everything queued.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_out", 32'd1, 32'd0);
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_out", {23'd0, alu_op, (sb_e.is_md ? md_op : 3'd0), is_md, illegal},
                    {23'd0, sb_e});
            end
        end
        if (reset || flush) sb_q.delete();
        else if (in_valid && in_ready) sb_q.push_back(cur_exp);
    end

    task automatic send(input vec_t v);
        bit done;
        done = 1'b0;
        drive(v.opc, v.f3, v.f7, v.alu, v.md, v.is_md, v.ill);
        for (int i = 0; i < 200 && !done; i++) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            #1;
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic m_seq(input string nm, input logic [2:0] f3, input int lat, input bit chk_nom);
        int first_v, n_start, start_at, n_busy, c;
        first_v = -1; n_start = 0; start_at = -1; n_busy = 0; c = 0;
        out_ready = 1'b1;
        drive(OPC_OP, f3, FNC7_MULDIV, ALU_XXX, f3, 1'b1, 1'b0);
        #1;
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        while (first_v < 0 && c < 100) begin
            c++;
            step();
            in_valid = 1'b0;
            if (md_start) begin n_start++; start_at = c; end
            if (busy) n_busy++;
            if (out_valid) first_v = c;
            if (chk_nom && c == 1)
                chk("nom_mul_illegal", {28'd0, nm_alu_op, nm_is_md, nm_illegal, nm_out_valid},
                    {28'd0, ALU_XXX, 1'b0, 1'b1, 1'b1});
        end
        chk({nm, "_out_valid_cycle"}, 32'(first_v), 32'(1 + lat));
        chk({nm, "_md_start_pulses"}, 32'(n_start), 32'd1);
        chk({nm, "_md_start_cycle"}, 32'(start_at), 32'd1);
        chk({nm, "_busy_cycles"}, 32'(n_busy), 32'(lat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // {opcode, funct3, funct7, alu_op, md_op, is_md, illegal}
        tv.push_back('{OPC_OP,    3'd0, 7'h00, ALU_ADD,    MD_MUL,    1'b0, 1'b0});
        tv.push_back('{OPC_OP,    3'd0, 7'h20, ALU_SUB,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OP,    3'd1, 7'h00, ALU_SLL,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OP,    3'd2, 7'h00, ALU_SLT,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OP,    3'd3, 7'h00, ALU_SLTU,   3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OP,    3'd4, 7'h00, ALU_XOR,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OP,    3'd5, 7'h00, ALU_SRL,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OP,    3'd5, 7'h20, ALU_SRA,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OP,    3'd6, 7'h00, ALU_OR,     3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OP,    3'd7, 7'h00, ALU_AND,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OP,    3'd1, 7'h20, ALU_XXX,    3'd0,      1'b0, 1'b1});
        tv.push_back('{OPC_OP,    3'd0, 7'h02, ALU_XXX,    3'd0,      1'b0, 1'b1});
        tv.push_back('{OPC_OP,    3'd0, 7'h01, ALU_XXX,    MD_MUL,    1'b1, 1'b0});
        tv.push_back('{OPC_OP,    3'd1, 7'h01, ALU_XXX,    MD_MULH,   1'b1, 1'b0});
        tv.push_back('{OPC_OP,    3'd2, 7'h01, ALU_XXX,    MD_MULHSU, 1'b1, 1'b0});
        tv.push_back('{OPC_OP,    3'd3, 7'h01, ALU_XXX,    MD_MULHU,  1'b1, 1'b0});
        tv.push_back('{OPC_OP,    3'd4, 7'h01, ALU_XXX,    MD_DIV,    1'b1, 1'b0});
        tv.push_back('{OPC_OP,    3'd5, 7'h01, ALU_XXX,    MD_DIVU,   1'b1, 1'b0});
        tv.push_back('{OPC_OP,    3'd6, 7'h01, ALU_XXX,    MD_REM,    1'b1, 1'b0});
        tv.push_back('{OPC_OP,    3'd7, 7'h01, ALU_XXX,    MD_REMU,   1'b1, 1'b0});
        tv.push_back('{OPC_OPIMM, 3'd0, 7'h20, ALU_ADD,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OPIMM, 3'd1, 7'h00, ALU_SLL,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OPIMM, 3'd1, 7'h20, ALU_XXX,    3'd0,      1'b0, 1'b1});
        tv.push_back('{OPC_OPIMM, 3'd5, 7'h00, ALU_SRL,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OPIMM, 3'd5, 7'h20, ALU_SRA,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OPIMM, 3'd5, 7'h01, ALU_XXX,    3'd0,      1'b0, 1'b1});
        tv.push_back('{OPC_OPIMM, 3'd4, 7'h7f, ALU_XOR,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OPIMM, 3'd3, 7'h55, ALU_SLTU,   3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_OPIMM, 3'd7, 7'h00, ALU_AND,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_LUI,   3'd3, 7'h11, ALU_COPY_B, 3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_AUIPC, 3'd0, 7'h00, ALU_ADD,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_JAL,   3'd0, 7'h00, ALU_ADD,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_JALR,  3'd0, 7'h00, ALU_ADD,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_BRANCH,3'd1, 7'h00, ALU_ADD,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_LOAD,  3'd2, 7'h00, ALU_ADD,    3'd0,      1'b0, 1'b0});
        tv.push_back('{OPC_STORE, 3'd2, 7'h00, ALU_ADD,    3'd0,      1'b0, 1'b0});
        tv.push_back('{7'h7f,     3'd0, 7'h00, ALU_XXX,    3'd0,      1'b0, 1'b1});

        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("reset_outputs", {22'd0, out_valid, alu_op, md_op, is_md, illegal, md_start, busy},
            {22'd0, 1'b0, ALU_XXX, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back ADD, SUB with no bubble.
        drive(OPC_OP, 3'd0, FNC7_BASE, ALU_ADD, 3'd0, 1'b0, 1'b0);
        #1;
        chk("b2b_in_ready0", 32'(in_ready), 32'd1);
        step();
        chk("b2b_c1", {27'd0, out_valid, alu_op}, {27'd0, 1'b1, ALU_ADD});
        drive(OPC_OP, 3'd0, FNC7_ALT, ALU_SUB, 3'd0, 1'b0, 1'b0);
        #1;
        chk("b2b_in_ready1", 32'(in_ready), 32'd1);
        step();
        chk("b2b_c2", {27'd0, out_valid, alu_op}, {27'd0, 1'b1, ALU_SUB});
        idle(2);

        // Backpressure: LUI held for 3 cycles, pending ADD taken on release.
        drive(OPC_LUI, 3'd0, 7'h00, ALU_COPY_B, 3'd0, 1'b0, 1'b0);
        step();
        drive(OPC_OP, 3'd0, FNC7_BASE, ALU_ADD, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            out_ready = 1'b0;
            #1;
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            step();
            chk("bp_held", {27'd0, out_valid, alu_op}, {27'd0, 1'b1, ALU_COPY_B});
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp_next_op", {27'd0, out_valid, alu_op}, {27'd0, 1'b1, ALU_ADD});
        idle(2);

        for (int i = 0; i < tv.size(); i++) send(tv[i]);
        idle(2);
        rnd = 1'b1;
        for (int i = 0; i < tv.size(); i++) send(tv[tv.size() - 1 - i]);
        rnd = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin step(); n++; end
        chk("sb_drain", 32'(sb_q.size()), 32'd0);
        idle(3);

        m_seq("mul", MD_MUL, 2, 1'b1);
        idle(2);
        m_seq("divu", MD_DIVU, 32, 1'b0);
        idle(2);

        // Flush in cycle 10 of a DIV, with a competing op offered that cycle.
        drive(OPC_OP, MD_DIV, FNC7_MULDIV, ALU_XXX, MD_DIV, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        repeat (9) step();
        chk("fl_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        drive(OPC_OP, 3'd0, FNC7_BASE, ALU_ADD, 3'd0, 1'b0, 1'b0);
        #1;
        chk("fl_in_ready_low", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_after", {30'd0, busy, out_valid}, 32'd0);
        #1;
        chk("fl_in_ready_back", 32'(in_ready), 32'd1);
        n = 0;
        repeat (40) begin step(); if (out_valid) n++; end
        chk("fl_no_late_valid", 32'(n), 32'd0);

        // Flush in HOLD drops the simultaneous accept; registered decode stays put.
        drive(OPC_LUI, 3'd0, 7'h00, ALU_COPY_B, 3'd0, 1'b0, 1'b0);
        step();
        drive(OPC_OP, 3'd0, FNC7_ALT, ALU_SUB, 3'd0, 1'b0, 1'b0);
        flush = 1'b1;
        #1;
        chk("flh_in_ready_low", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flh_after", {27'd0, out_valid, alu_op}, {27'd0, 1'b0, ALU_COPY_B});
        idle(2);

        // Synchronous reset while holding an illegal result under backpressure.
        drive(7'h7f, 3'd0, 7'h00, ALU_XXX, 3'd0, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        chk("rh_holding", {30'd0, out_valid, illegal}, {30'd0, 1'b1, 1'b1});
        reset = 1'b1;
        step();
        chk("rh_outputs", {22'd0, out_valid, alu_op, md_op, is_md, illegal, md_start, busy},
            {22'd0, 1'b0, ALU_XXX, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        reset = 1'b0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
